irq_request_unit: RTL and testbench

Conditions the external interrupt lines into the `int_sig` vector that the interrupt controller consumes. It sits directly upstream of the controller in the processor top level:
- synchronizes asynchronous request lines and detects rising edges;
- latches pending requests and applies a mask;
- arbitrates by fixed priority and presents one request at a time;
- retires each request using the controller's `ISR_running` status.

---
 rtl/irq_request_unit.sv | 128 ++++++++++++
 tb/tb_irq_request_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_request_unit.sv
// Interrupt request conditioning: synchronizes external lines, latches rising-edge
// requests under a mask and presents them one at a time to the interrupt controller.
`ifndef INT_SIG_WIDTH
`define INT_SIG_WIDTH 4
`endif

module irq_request_unit #(
    parameter int SYNC_STAGES = 2,
    parameter int REQ_TIMEOUT = 15,
    localparam int W    = `INT_SIG_WIDTH,
    localparam int ID_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    irq_in,
    input  logic [W-1:0]    irq_mask,
    input  logic            missed_clr,
    input  logic            ISR_running,
    output logic [W-1:0]    int_sig,
    output logic [W-1:0]    irq_pending,
    output logic [ID_W-1:0] irq_active_id,
    output logic [W-1:0]    irq_missed
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE, COOLDOWN} state_t;

    state_t            state, state_nxt;
    logic [W-1:0]      sync_p [SYNC_STAGES];
    logic [W-1:0]      prev_p;
    logic [W-1:0]      edge_det, eligible, active;
    logic [W-1:0]      int_sig_nxt, pending_nxt, missed_nxt;
    logic [ID_W-1:0]   id_nxt, lowest_id;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              ack;

    // Synchronizer chain and edge-detect history
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_p[k] <= '0;
            prev_p <= '0;
        end else begin
            sync_p[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_p[k] <= sync_p[k-1];
            prev_p <= sync_p[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_p[SYNC_STAGES-1] & ~prev_p;
    assign eligible = irq_pending & ~irq_mask;
    assign active   = (state != IDLE) ? (W'(1) << irq_active_id) : '0;

    always_comb begin
        lowest_id = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (eligible[i]) lowest_id = ID_W'(i);
        end
    end

    always_comb begin
        state_nxt   = state;
        int_sig_nxt = int_sig;
        id_nxt      = irq_active_id;
        cnt_nxt     = cnt;
        ack         = 1'b0;
        case (state)
            IDLE: begin
                if (!ISR_running && |eligible) begin
                    id_nxt      = lowest_id;
                    int_sig_nxt = W'(1) << lowest_id;
                    cnt_nxt     = '0;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                if (ISR_running) begin
                    ack         = 1'b1;
                    int_sig_nxt = '0;
                    state_nxt   = SERVICE;
                end else if (irq_mask[irq_active_id] || cnt == CNT_W'(REQ_TIMEOUT)) begin
                    int_sig_nxt = '0;
                    state_nxt   = COOLDOWN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SERVICE: begin
                if (!ISR_running) state_nxt = COOLDOWN;
            end
            COOLDOWN: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // An edge on a line that is pending or being handled is recorded as missed, never re-latched
    always_comb begin
        pending_nxt = irq_pending;
        missed_nxt  = missed_clr ? '0 : irq_missed;
        if (ack) pending_nxt[irq_active_id] = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (edge_det[i] && !irq_mask[i]) begin
                if (!irq_pending[i] && !active[i]) pending_nxt[i] = 1'b1;
                else                               missed_nxt[i]  = 1'b1;
            end
        end
    end

    // Arbiter state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            int_sig       <= '0;
            irq_active_id <= '0;
            cnt           <= '0;
            irq_pending   <= '0;
            irq_missed    <= '0;
        end else begin
            state         <= state_nxt;
            int_sig       <= int_sig_nxt;
            irq_active_id <= id_nxt;
            cnt           <= cnt_nxt;
            irq_pending   <= pending_nxt;
            irq_missed    <= missed_nxt;
        end
    end

endmodule

// File: tb/tb_irq_request_unit.sv
// Directed bench for irq_request_unit: a cycle model built from the request/arbitration
// rules is compared every cycle, plus literal expectations along each scenario.
`ifndef INT_SIG_WIDTH
`define INT_SIG_WIDTH 4
`endif

module tb_irq_request_unit;

    localparam int W    = `INT_SIG_WIDTH;
    localparam int ID_W = (W > 1) ? $clog2(W) : 1;
    localparam int SP   = 2;
    localparam int TO   = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [W-1:0]    irq_in = '0;
    logic [W-1:0]    irq_mask = '0;
    logic            missed_clr = 1'b0;
    logic            ISR_running = 1'b0;
    logic [W-1:0]    int_sig;
    logic [W-1:0]    irq_pending;
    logic [ID_W-1:0] irq_active_id;
    logic [W-1:0]    irq_missed;

    int n_pass  = 0;
    int n_total = 0;

    irq_request_unit #(.SYNC_STAGES(SP), .REQ_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask),
        .missed_clr(missed_clr), .ISR_running(ISR_running), .int_sig(int_sig),
        .irq_pending(irq_pending), .irq_active_id(irq_active_id), .irq_missed(irq_missed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: input history, per-line pending/missed, and the line being handled
    logic [W-1:0] hist [SP];
    logic [W-1:0] m_prev, m_pend, m_miss, m_sig;
    int m_cur, m_id, m_age;
    bit m_serving, m_cooling, started;

    always @(posedge clk) begin
        logic [W-1:0] s, np, nm;
        int cur_old, pick;
        if (rst) begin
            for (int k = 0; k < SP; k++) hist[k] = '0;
            m_prev = '0; m_pend = '0; m_miss = '0; m_sig = '0;
            m_cur = -1; m_id = 0; m_age = 0; m_serving = 0; m_cooling = 0;
            started = 1;
        end else begin
            s = hist[SP-1];
            np = m_pend;
            nm = missed_clr ? '0 : m_miss;
            cur_old = m_cur;
            if (cur_old >= 0 && !m_serving && !m_cooling) begin
                if (ISR_running) begin
                    np[cur_old] = 1'b0; m_sig = '0; m_serving = 1;
                end else if (irq_mask[cur_old] || m_age == TO) begin
                    m_sig = '0; m_cooling = 1;
                end else begin
                    m_age++;
                end
            end else if (m_serving) begin
                if (!ISR_running) begin m_serving = 0; m_cooling = 1; end
            end else if (m_cooling) begin
                m_cooling = 0; m_cur = -1;
            end else if (!ISR_running) begin
                pick = -1;
                for (int i = W - 1; i >= 0; i--) if (m_pend[i] && !irq_mask[i]) pick = i;
                if (pick >= 0) begin
                    m_cur = pick; m_id = pick; m_age = 0; m_sig = '0; m_sig[pick] = 1'b1;
                end
            end
            for (int i = 0; i < W; i++) begin
                if (s[i] && !m_prev[i] && !irq_mask[i]) begin
                    if (!m_pend[i] && cur_old != i) np[i] = 1'b1;
                    else                            nm[i] = 1'b1;
                end
            end
            m_pend = np; m_miss = nm; m_prev = s;
            for (int k = SP - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = irq_in;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("int_sig", 32'(int_sig), 32'(m_sig));
            chk("irq_pending", 32'(irq_pending), 32'(m_pend));
            chk("irq_missed", 32'(irq_missed), 32'(m_miss));
            chk("irq_active_id", 32'(irq_active_id), 32'(m_id));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        chk("reset int_sig", 32'(int_sig), 0);
        chk("reset pending", 32'(irq_pending), 0);
        chk("reset missed", 32'(irq_missed), 0);
        chk("reset id", 32'(irq_active_id), 0);

        // Single request on line 0, then a second edge while in service
        irq_in = 4'b0001;
        step(3);
        chk("single pending", 32'(irq_pending), 32'h1);
        chk("single int_sig early", 32'(int_sig), 0);
        step(1);
        chk("single int_sig", 32'(int_sig), 32'h1);
        chk("single id", 32'(irq_active_id), 0);
        ISR_running = 1'b1;
        step(1);
        chk("ack int_sig", 32'(int_sig), 0);
        chk("ack pending", 32'(irq_pending), 0);
        irq_in = 4'b0000;
        step(3);
        irq_in = 4'b0001;
        step(3);
        chk("missed set", 32'(irq_missed), 32'h1);
        chk("missed pending", 32'(irq_pending), 0);
        missed_clr = 1'b1;
        step(1);
        missed_clr = 1'b0;
        chk("missed clr", 32'(irq_missed), 0);
        ISR_running = 1'b0;
        step(3);
        chk("idle int_sig", 32'(int_sig), 0);

        // Priority: lines 1 and 2 together
        irq_in = 4'b0111;
        step(4);
        chk("prio first", 32'(int_sig), 32'h2);
        chk("prio first id", 32'(irq_active_id), 1);
        ISR_running = 1'b1;
        step(1);
        chk("prio pending", 32'(irq_pending), 32'h4);
        ISR_running = 1'b0;
        step(2);
        chk("prio gap", 32'(int_sig), 0);
        step(1);
        chk("prio second", 32'(int_sig), 32'h4);
        chk("prio second id", 32'(irq_active_id), 2);
        ISR_running = 1'b1;
        step(1);
        ISR_running = 1'b0;
        step(2);
        irq_in = 4'b0000;
        step(3);

        // Timeout and retry on line 3
        irq_in = 4'b1000;
        step(4);
        chk("to high 0", 32'(int_sig), 32'h8);
        for (int c = 1; c <= TO; c++) begin
            step(1);
            chk("to high", 32'(int_sig), 32'h8);
        end
        step(1);
        chk("to drop", 32'(int_sig), 0);
        chk("to pending", 32'(irq_pending), 32'h8);
        step(1);
        chk("to idle", 32'(int_sig), 0);
        step(1);
        chk("to retry", 32'(int_sig), 32'h8);
        chk("to retry pending", 32'(irq_pending), 32'h8);
        ISR_running = 1'b1;
        step(1);
        ISR_running = 1'b0;
        step(2);
        irq_in = 4'b0000;
        step(3);

        // Mask: edge on masked line dropped; masking the active line withdraws it
        irq_mask = 4'b0010;
        irq_in   = 4'b0010;
        step(4);
        chk("masked pending", 32'(irq_pending), 0);
        chk("masked int_sig", 32'(int_sig), 0);
        chk("masked missed", 32'(irq_missed), 0);
        irq_mask = 4'b0000;
        irq_in   = 4'b0000;
        step(3);
        irq_in = 4'b0100;
        step(4);
        chk("mask req", 32'(int_sig), 32'h4);
        irq_mask = 4'b0100;
        step(1);
        chk("mask drop", 32'(int_sig), 0);
        chk("mask keep pending", 32'(irq_pending), 32'h4);
        step(2);
        chk("mask hold", 32'(int_sig), 0);
        irq_mask = 4'b0000;
        step(1);
        chk("unmask req", 32'(int_sig), 32'h4);
        ISR_running = 1'b1;
        step(1);
        chk("unmask ack", 32'(irq_pending), 0);
        ISR_running = 1'b0;
        step(2);
        irq_in = 4'b0000;
        step(3);

        // Reset in the middle of a request
        irq_in = 4'b0001;
        step(4);
        chk("rst pre", 32'(int_sig), 32'h1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst int_sig", 32'(int_sig), 0);
        chk("rst pending", 32'(irq_pending), 0);
        chk("rst id", 32'(irq_active_id), 0);
        step(3);
        chk("rst re-pending", 32'(irq_pending), 32'h1);
        step(1);
        chk("rst re-request", 32'(int_sig), 32'h1);
        ISR_running = 1'b1;
        step(1);
        ISR_running = 1'b0;
        step(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
